// File: rtl/lcd_time_writer.sv
// -----------------------------------------------------------------------------
// lcd_time_writer
//
// Frame sequencer for the LCD byte interface. Each redraw request latches a
// 6-digit BCD time snapshot and sends one DDRAM-address instruction followed
// by the eight characters "HH:MM:SS". Each byte uses one handshake:
//   ISSUE      wait for lcd_ready, present the byte, raise lcd_send
//   PULSE      hold lcd_send for SEND_PULSE cycles
//   WAIT_ACK   wait for the interface to drop lcd_ready (the ack)
//   WAIT_READY wait for lcd_ready to return, then advance to the next byte
// A missing ack aborts the frame and sets a sticky error flag.
//
// Parameters
//   SEND_PULSE   cycles lcd_send is held high per byte (1..15)
//   LINE_ADDR    instruction byte sent first in every frame
//   ACK_TIMEOUT  max cycles from lcd_send rise to lcd_ready fall
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   update     in   one-cycle redraw request
//   time_bcd   in   {H1,H0,M1,M0,S1,S0}, 4-bit BCD each, H1 at [23:20]
//   lcd_ready  in   interface idle / init done
//   lcd_data   out  byte to interface data
//   lcd_send   out  to interface send_data
//   lcd_ins    out  to interface ins_data (0 = instruction, 1 = character)
//   busy       out  frame in progress
//   done       out  one-cycle pulse when a frame completes
//   err        out  sticky timeout flag, cleared by reset or a completed frame
// -----------------------------------------------------------------------------
module lcd_time_writer #(
    parameter int unsigned SEND_PULSE  = 4,
    parameter logic [7:0]  LINE_ADDR   = 8'h80,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic [23:0] time_bcd,
    input  logic        lcd_ready,
    output logic [7:0]  lcd_data,
    output logic        lcd_send,
    output logic        lcd_ins,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Timeout counter is at least 16 bits, wider only if ACK_TIMEOUT needs it.
    localparam int TO_W = ($clog2(ACK_TIMEOUT + 1) > 16) ? $clog2(ACK_TIMEOUT + 1) : 16;

    localparam logic [3:0]      PULSE_LAST = 4'(SEND_PULSE - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]      LAST_IDX   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_PULSE,
        S_WAIT_ACK,
        S_WAIT_READY,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [23:0]     snap_q, snap_d;
    logic [3:0]      idx_q, idx_d;
    logic            pend_q, pend_d;
    logic            ack_q, ack_d;
    logic [3:0]      pcnt_q, pcnt_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [7:0]      data_q, data_d;
    logic            send_q, send_d;
    logic            ins_q, ins_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // ASCII for one BCD digit; any non-decimal nibble shows as '?'.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        if (d > 4'd9) begin
            return 8'h3F;
        end
        return 8'h30 + {4'h0, d};
    endfunction

    // Byte for position idx of the frame: address, then H1 H0 : M1 M0 : S1 S0.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [23:0] snap);
        logic [7:0] b;
        case (idx)
            4'd0:    b = LINE_ADDR;
            4'd1:    b = digit_char(snap[23:20]);
            4'd2:    b = digit_char(snap[19:16]);
            4'd3:    b = 8'h3A;
            4'd4:    b = digit_char(snap[15:12]);
            4'd5:    b = digit_char(snap[11:8]);
            4'd6:    b = 8'h3A;
            4'd7:    b = digit_char(snap[7:4]);
            4'd8:    b = digit_char(snap[3:0]);
            default: b = 8'h3F;
        endcase
        return b;
    endfunction

    // Saturating increment so a stuck interface can never wrap the timeout.
    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        ack_d   = ack_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q;
        data_d  = data_q;
        send_d  = send_q;
        ins_d   = ins_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        // Requests arriving mid-frame collapse into a single follow-up frame.
        if (update && busy_q) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (update || pend_q) begin
                    snap_d  = time_bcd;
                    pend_d  = 1'b0;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (lcd_ready) begin
                    data_d  = frame_byte(idx_q, snap_q);
                    ins_d   = (idx_q != 4'd0);
                    send_d  = 1'b1;
                    pcnt_d  = 4'd0;
                    tcnt_d  = '0;
                    ack_d   = 1'b0;
                    state_d = S_PULSE;
                end
            end

            S_PULSE: begin
                tcnt_d = sat_inc(tcnt_q);
                // The interface may drop ready while the pulse is still high;
                // remember it so WAIT_ACK does not miss a short ack.
                if (!lcd_ready) begin
                    ack_d = 1'b1;
                end
                if (pcnt_q >= PULSE_LAST) begin
                    send_d  = 1'b0;
                    state_d = S_WAIT_ACK;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end

            S_WAIT_ACK: begin
                tcnt_d = sat_inc(tcnt_q);
                if (ack_q || !lcd_ready) begin
                    state_d = S_WAIT_READY;
                end else if (tcnt_q >= TO_LAST) begin
                    state_d = S_ABORT;
                end
            end

            S_WAIT_READY: begin
                if (lcd_ready) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ABORT: begin
                // Pending request is kept so the redraw is retried from IDLE.
                send_d  = 1'b0;
                busy_d  = 1'b0;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs are registered, so reset release cannot glitch lcd_send.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
            ins_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
            data_q  <= data_d;
            send_q  <= send_d;
            ins_q   <= ins_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign lcd_data = data_q;
    assign lcd_send = send_q;
    assign lcd_ins  = ins_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lcd_time_writer.sv
`timescale 1ns/1ps
module tb_lcd_time_writer;

    localparam int SEND_PULSE  = 4;
    localparam int ACK_TIMEOUT = 1000;
    localparam int NV          = 5;

    typedef struct {
        logic [23:0] tbcd;
        logic [63:0] chars;
    } vec_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        update    = 1'b0;
    logic [23:0] time_bcd  = 24'h0;
    logic        lcd_ready = 1'b1;
    logic [7:0]  lcd_data;
    logic        lcd_send;
    logic        lcd_ins;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q[$];
    vec_t       tbl[NV];

    int mode       = 0;   // 0 normal ready model, 1 never acks, 2 held low
    int low_cnt    = 0;
    int done_cnt   = 0;
    int sends_seen = 0;
    int hi_cnt     = 0;
    logic       prev_send = 1'b0;
    logic [8:0] held      = 9'h0;

    lcd_time_writer #(
        .SEND_PULSE (SEND_PULSE),
        .LINE_ADDR  (8'h80),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .update   (update),
        .time_bcd (time_bcd),
        .lcd_ready(lcd_ready),
        .lcd_data (lcd_data),
        .lcd_send (lcd_send),
        .lcd_ins  (lcd_ins),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready model: drops half a cycle after a send is seen, back high 20 cycles later.
    always @(negedge clk) begin
        if (mode == 2) begin
            lcd_ready = 1'b0;
            low_cnt   = 0;
        end else if (mode == 1) begin
            lcd_ready = 1'b1;
        end else if (!lcd_ready) begin
            if (low_cnt > 0) low_cnt--;
            else lcd_ready = 1'b1;
        end else if (lcd_send) begin
            lcd_ready = 1'b0;
            low_cnt   = 19;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_send = 1'b0;
            hi_cnt    = 0;
        end else begin
            if (lcd_send && !prev_send) begin
                sends_seen++;
                hi_cnt = 1;
                held   = {lcd_ins, lcd_data};
                check("send_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("byte", 32'({lcd_ins, lcd_data}), 32'(exp_q.pop_front()));
                end
            end else if (lcd_send) begin
                hi_cnt++;
                check("data_stable", 32'({lcd_ins, lcd_data}), 32'(held));
            end else if (prev_send) begin
                check("pulse_width", 32'(hi_cnt), 32'(SEND_PULSE));
            end
            if (done) begin
                done_cnt++;
                check("done_with_busy_low", 32'(busy), 32'd0);
            end
            prev_send = lcd_send;
        end
    end

    task automatic push_frame(input logic [63:0] chars);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({1'b1, chars[63 - 8*i -: 8]});
        end
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int start;
        int c;
        start = done_cnt;
        c = 0;
        while ((done_cnt - start) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(done_cnt - start), 32'(n));
    endtask

    task automatic wait_sends(input int target, input int budget, input string name);
        int c;
        c = 0;
        while (sends_seen < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(sends_seen >= target), 32'd1);
    endtask

    initial begin
        int s0;
        int d0;
        int c;

        tbl[0] = '{24'h123456, 64'h31_32_3A_33_34_3A_35_36};
        tbl[1] = '{24'hA9595F, 64'h3F_39_3A_35_39_3A_35_3F};
        tbl[2] = '{24'h000001, 64'h30_30_3A_30_30_3A_30_31};
        tbl[3] = '{24'h235959, 64'h32_33_3A_35_39_3A_35_39};
        tbl[4] = '{24'h9B70C0, 64'h39_3F_3A_37_30_3A_3F_30};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({lcd_data, lcd_send, lcd_ins, busy, done, err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame with start latency
        time_bcd = tbl[0].tbcd;
        push_frame(tbl[0].chars);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check("latency_busy", 32'(busy), 32'd1);
        check("latency_send_not_yet", 32'(lcd_send), 32'd0);
        @(negedge clk);
        check("latency_send", 32'(lcd_send), 32'd1);
        wait_frames(1, 2000, "basic_frame_done");
        check("basic_queue_drained", 32'(exp_q.size()), 32'd0);
        check("basic_err", 32'(err), 32'd0);

        // Table of snapshots, including invalid BCD
        for (int i = 1; i < NV; i++) begin
            time_bcd = tbl[i].tbcd;
            push_frame(tbl[i].chars);
            pulse_update();
            wait_frames(1, 2000, "table_frame_done");
            check("table_queue_drained", 32'(exp_q.size()), 32'd0);
            check("table_busy_low", 32'(busy), 32'd0);
            check("table_err", 32'(err), 32'd0);
        end

        // Updates during busy collapse into one follow-up frame
        time_bcd = tbl[3].tbcd;
        push_frame(tbl[3].chars);
        push_frame(tbl[2].chars);
        s0 = sends_seen;
        pulse_update();
        wait_sends(s0 + 2, 500, "pending_first_bytes");
        time_bcd = tbl[2].tbcd;
        for (int k = 0; k < 3; k++) begin
            pulse_update();
            repeat (3) @(negedge clk);
        end
        wait_frames(2, 4000, "pending_two_frames");
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        check("no_extra_frame", 32'(done_cnt - d0), 32'd0);
        check("pending_busy_low", 32'(busy), 32'd0);
        check("pending_queue_drained", 32'(exp_q.size()), 32'd0);

        // Timeout: interface never acks, pending update retried after fix
        mode = 1;
        exp_q.push_back({1'b0, 8'h80});
        time_bcd = tbl[1].tbcd;
        pulse_update();
        pulse_update();
        time_bcd = tbl[4].tbcd;
        push_frame(tbl[4].chars);
        c = 0;
        while (!err && c < 1500) begin
            @(negedge clk);
            c++;
        end
        mode = 0;
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_send", 32'(lcd_send), 32'd0);
        check("timeout_cycles_in_range", 32'(c >= ACK_TIMEOUT - 10 && c <= ACK_TIMEOUT + 10), 32'd1);
        @(negedge clk);
        check("retry_busy", 32'(busy), 32'd1);
        check("err_sticky", 32'(err), 32'd1);
        wait_frames(1, 2000, "retry_frame_done");
        check("retry_err_cleared", 32'(err), 32'd0);
        check("retry_queue_drained", 32'(exp_q.size()), 32'd0);

        // Ready held low at start
        mode = 2;
        repeat (2) @(negedge clk);
        time_bcd = tbl[0].tbcd;
        push_frame(tbl[0].chars);
        s0 = sends_seen;
        pulse_update();
        repeat (20) @(negedge clk);
        check("no_send_while_not_ready", 32'(sends_seen - s0), 32'd0);
        check("busy_while_not_ready", 32'(busy), 32'd1);
        mode = 0;
        c = 0;
        while (c < 10) begin
            @(posedge clk);
            c++;
            if (lcd_ready) break;
        end
        #1;
        check("send_after_ready_rise", 32'(lcd_send), 32'd1);
        check("first_byte_after_ready", 32'({lcd_ins, lcd_data}), 32'h080);
        wait_frames(1, 2000, "late_ready_frame_done");

        // Reset mid-frame at byte 4
        time_bcd = tbl[0].tbcd;
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b1, 8'h31});
        exp_q.push_back({1'b1, 8'h32});
        exp_q.push_back({1'b1, 8'h3A});
        exp_q.push_back({1'b1, 8'h33});
        s0 = sends_seen;
        pulse_update();
        wait_sends(s0 + 5, 2000, "reach_byte4");
        rst = 1'b1;
        #1;
        check("midframe_reset_outputs", 32'({lcd_data, lcd_send, lcd_ins, busy, done, err}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({lcd_send, busy}), 32'd0);
        end
        time_bcd = tbl[1].tbcd;
        push_frame(tbl[1].chars);
        pulse_update();
        wait_frames(1, 2000, "post_reset_frame_done");

        repeat (5) @(negedge clk);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
